// File: rtl/n64_pkg.sv
// Shared types and constants for the N64 Joybus transceiver: FSM states,
// bit timing in 1 us units, and the common console opcodes.
package n64_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_LOW,
    S_TX_HIGH,
    S_TX_STOP,
    S_RX_WAIT,
    S_RX_BIT,
    S_FINISH
  } state_e;

  localparam int T_SHORT  = 1;
  localparam int T_LONG   = 3;
  localparam int T_BIT    = 4;
  localparam int T_SAMPLE = 2;

  localparam logic [7:0] CMD_INFO  = 8'h00;
  localparam logic [7:0] CMD_POLL  = 8'h01;
  localparam logic [7:0] CMD_RESET = 8'hFF;

endpackage

// File: rtl/n64_line_sync.sv
// Two-flop synchroniser for the Joybus line plus a falling-edge detector
// built from the synchronised level and its one-cycle-delayed copy.
module n64_line_sync (
  input  logic clk,
  input  logic Reset,
  input  logic din,
  output logic line_o,
  output logic fall_o
);

  logic s1_q, s2_q, prev_q;
  logic s1_d, s2_d, prev_d;

  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // Idle Joybus is pulled high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (Reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign line_o = s2_q;
  assign fall_o = prev_q & ~s2_q;

endmodule

// File: rtl/n64_joybus_xcvr.sv
// N64 Joybus transceiver: sends a variable-length command with stop bit on
// the open-drain line, then decodes a variable-length response with timeout.
module n64_joybus_xcvr
  import n64_pkg::*;
#(
  parameter int US_CYCLES  = 50,
  parameter int CMD_MAX    = 24,
  parameter int RSP_MAX    = 32,
  parameter int TIMEOUT_US = 100
) (
  input  logic                           clk,
  input  logic                           Reset,
  inout  wire                            N64Data,
  input  logic                           start,
  input  logic [CMD_MAX-1:0]             cmd,
  input  logic [$clog2(CMD_MAX+1)-1:0]   cmd_len,
  input  logic [$clog2(RSP_MAX+1)-1:0]   rsp_len,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout,
  output logic [RSP_MAX-1:0]             rsp_data,
  output logic [$clog2(RSP_MAX+1)-1:0]   rsp_count
);

  localparam int LW = $clog2(CMD_MAX+1);
  localparam int RW = $clog2(RSP_MAX+1);
  localparam int CW = $clog2(TIMEOUT_US*US_CYCLES+1);

  localparam logic [CW-1:0] C_SHORT  = CW'(T_SHORT*US_CYCLES-1);
  localparam logic [CW-1:0] C_LOW0   = CW'(T_LONG*US_CYCLES-1);
  localparam logic [CW-1:0] C_HIGH1  = CW'((T_BIT-T_SHORT)*US_CYCLES-1);
  localparam logic [CW-1:0] C_HIGH0  = CW'((T_BIT-T_LONG)*US_CYCLES-1);
  localparam logic [CW-1:0] C_SAMPLE = CW'(T_SAMPLE*US_CYCLES-1);
  localparam logic [CW-1:0] C_TO     = CW'(TIMEOUT_US*US_CYCLES-1);

  logic line_s, fall_s;

  n64_line_sync u_sync (
    .clk   (clk),
    .Reset (Reset),
    .din   (N64Data),
    .line_o(line_s),
    .fall_o(fall_s)
  );

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CMD_MAX-1:0] cmd_sr_q, cmd_sr_d;
  logic [LW-1:0]      bits_q, bits_d;
  logic [RW-1:0]      rsp_len_q, rsp_len_d;
  logic [RSP_MAX-1:0] rsp_data_q, rsp_data_d;
  logic [RW-1:0]      rsp_count_q, rsp_count_d;
  logic               drive_low_q, drive_low_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               wait_hi_q, wait_hi_d;
  logic [LW-1:0]      clen;
  logic [RW-1:0]      rlen;

  always_comb begin
    clen = cmd_len;
    if (cmd_len == '0)                clen = LW'(1);
    else if (cmd_len > LW'(CMD_MAX))  clen = LW'(CMD_MAX);
    rlen = (rsp_len > RW'(RSP_MAX)) ? RW'(RSP_MAX) : rsp_len;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_sr_d    = cmd_sr_q;
    bits_d      = bits_q;
    rsp_len_d   = rsp_len_q;
    rsp_data_d  = rsp_data_q;
    rsp_count_d = rsp_count_q;
    drive_low_d = drive_low_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    timeout_d   = timeout_q;
    wait_hi_d   = wait_hi_q;
    case (state_q)
      S_IDLE: if (start) begin
        // Left-align so the next bit to send is always the MSB.
        cmd_sr_d    = cmd << (CMD_MAX - int'(clen));
        bits_d      = clen;
        rsp_len_d   = rlen;
        rsp_data_d  = '0;
        rsp_count_d = '0;
        timeout_d   = 1'b0;
        busy_d      = 1'b1;
        drive_low_d = 1'b1;
        cnt_d       = cmd_sr_d[CMD_MAX-1] ? C_SHORT : C_LOW0;
        state_d     = S_TX_LOW;
      end
      S_TX_LOW: begin
        if (cnt_q == '0) begin
          drive_low_d = 1'b0;
          cnt_d       = cmd_sr_q[CMD_MAX-1] ? C_HIGH1 : C_HIGH0;
          state_d     = S_TX_HIGH;
        end else cnt_d = cnt_q - CW'(1);
      end
      S_TX_HIGH: begin
        if (cnt_q == '0) begin
          bits_d      = bits_q - LW'(1);
          cmd_sr_d    = cmd_sr_q << 1;
          drive_low_d = 1'b1;
          if (bits_q == LW'(1)) begin
            cnt_d   = C_SHORT;
            state_d = S_TX_STOP;
          end else begin
            cnt_d   = cmd_sr_d[CMD_MAX-1] ? C_SHORT : C_LOW0;
            state_d = S_TX_LOW;
          end
        end else cnt_d = cnt_q - CW'(1);
      end
      S_TX_STOP: begin
        if (cnt_q == '0) begin
          drive_low_d = 1'b0;
          if (rsp_len_q == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_FINISH;
          end else begin
            cnt_d   = C_TO;
            state_d = S_RX_WAIT;
          end
        end else cnt_d = cnt_q - CW'(1);
      end
      S_RX_WAIT: begin
        if (fall_s) begin
          cnt_d     = C_SAMPLE;
          wait_hi_d = 1'b0;
          state_d   = S_RX_BIT;
        end else if (cnt_q == '0) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_FINISH;
        end else cnt_d = cnt_q - CW'(1);
      end
      S_RX_BIT: begin
        if (!wait_hi_q) begin
          if (cnt_q == '0) begin
            rsp_data_d  = {rsp_data_q[RSP_MAX-2:0], line_s};
            rsp_count_d = rsp_count_q + RW'(1);
            cnt_d       = C_TO;
            if (rsp_count_d == rsp_len_q) wait_hi_d = 1'b1;
            else                          state_d   = S_RX_WAIT;
          end else cnt_d = cnt_q - CW'(1);
        end else if (line_s || cnt_q == '0) begin
          // Last bit in; a line stuck low here is reported as a timeout.
          timeout_d = ~line_s;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_FINISH;
        end else cnt_d = cnt_q - CW'(1);
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_sr_q    <= '0;
      bits_q      <= '0;
      rsp_len_q   <= '0;
      rsp_data_q  <= '0;
      rsp_count_q <= '0;
      drive_low_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      wait_hi_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_sr_q    <= cmd_sr_d;
      bits_q      <= bits_d;
      rsp_len_q   <= rsp_len_d;
      rsp_data_q  <= rsp_data_d;
      rsp_count_q <= rsp_count_d;
      drive_low_q <= drive_low_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      wait_hi_q   <= wait_hi_d;
    end
  end

  assign N64Data   = drive_low_q ? 1'b0 : 1'bz;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_count = rsp_count_q;

endmodule

// File: tb/tb_n64_joybus_xcvr.sv
// Bench for n64_joybus_xcvr: table of transactions (fixed + random) against a
// unit-timing line model, plus hand sequences for start-at-done and mid-TX reset.
module tb_n64_joybus_xcvr;
  import n64_pkg::*;

  localparam int US = 4;
  localparam int TO = 8;
  localparam int CMAX = 24;
  localparam int RMAX = 32;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] cmd = '0;
  logic [4:0]  cmd_len = '0;
  logic [5:0]  rsp_len = '0;
  logic        busy, done, timeout;
  logic [31:0] rsp_data;
  logic [5:0]  rsp_count;
  logic        dev_low = 1'b0;
  wire         n64_line;

  pullup (n64_line);
  assign n64_line = dev_low ? 1'b0 : 1'bz;

  n64_joybus_xcvr #(.US_CYCLES(US), .CMD_MAX(CMAX), .RSP_MAX(RMAX), .TIMEOUT_US(TO)) dut (
    .clk(clk), .Reset(Reset), .N64Data(n64_line), .start(start), .cmd(cmd),
    .cmd_len(cmd_len), .rsp_len(rsp_len), .busy(busy), .done(done),
    .timeout(timeout), .rsp_data(rsp_data), .rsp_count(rsp_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          done_cnt = 0;
  int          d_cyc = 0;
  logic        d_to;
  logic [5:0]  d_cnt;
  logic [31:0] d_data;
  always @(negedge clk) if (done) begin
    done_cnt = done_cnt + 1;
    d_cyc  = cyc;
    d_to   = timeout;
    d_cnt  = rsp_count;
    d_data = rsp_data;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [23:0] cmd;
    int          cmd_len;
    int          rsp_len;
    logic [31:0] dev_val;
    int          dev_n;
    bit          dev_stop;
    bit          restart;
    bit          exp_to;
    int          exp_cnt;
    logic [31:0] exp_data;
  } vec_t;

  function automatic vec_t mk(input logic [23:0] c, input int cl, input int rl,
                              input logic [31:0] dv, input int dn, input bit ds,
                              input bit rs, input bit eto, input int ecnt,
                              input logic [31:0] edat);
    vec_t v;
    v.cmd = c; v.cmd_len = cl; v.rsp_len = rl; v.dev_val = dv; v.dev_n = dn;
    v.dev_stop = ds; v.restart = rs; v.exp_to = eto; v.exp_cnt = ecnt; v.exp_data = edat;
    return v;
  endfunction

  // Reference: the block keeps the first min(device bits, saturated length) bits.
  function automatic void model(inout vec_t v);
    int eff, n;
    logic [63:0] full, mask;
    eff  = (v.rsp_len > RMAX) ? RMAX : v.rsp_len;
    n    = (v.dev_n < eff) ? v.dev_n : eff;
    full = {32'h0, v.dev_val};
    mask = (64'h1 << n) - 64'h1;
    v.exp_cnt  = n;
    v.exp_to   = (eff > 0) && (n < eff);
    v.exp_data = 32'((full >> (v.dev_n - n)) & mask);
  endfunction

  // Expected line level t cycles after the first low of a command.
  function automatic logic tx_level(input logic [23:0] c, input int len, input int t);
    logic b;
    int p;
    if (t >= 16*len) return ((t - 16*len) < US) ? 1'b0 : 1'b1;
    b = c[len - 1 - t/16];
    p = t % 16;
    return (p < (b ? US : 3*US)) ? 1'b0 : 1'b1;
  endfunction

  task automatic send_bit(input logic b);
    dev_low = 1'b1;
    repeat (b ? US : 3*US) tick;
    dev_low = 1'b0;
    repeat (b ? 3*US : US) tick;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int base, len, txc, mism, k, sc, eff;
    string nm;
    len  = (v.cmd_len == 0) ? 1 : v.cmd_len;
    eff  = (v.rsp_len > RMAX) ? RMAX : v.rsp_len;
    txc  = (4*len + 1) * US;
    base = done_cnt;
    cmd = v.cmd; cmd_len = 5'(v.cmd_len); rsp_len = 6'(v.rsp_len);
    sc = cyc;
    start = 1'b1;
    tick;
    start = 1'b0;
    nm = $sformatf("v%0d", idx);
    chk({nm, " busy_at_N+1"}, busy, 1);
    mism = 0;
    for (int t = 0; t < txc; t++) begin
      if (n64_line !== tx_level(v.cmd, len, t)) mism++;
      if (v.restart && t == 20) begin
        cmd = ~v.cmd; cmd_len = 5'd3; rsp_len = 6'd5; start = 1'b1;
      end
      tick;
      start = 1'b0; cmd = v.cmd; cmd_len = 5'(v.cmd_len); rsp_len = 6'(v.rsp_len);
    end
    chk({nm, " tx_wave_mismatches"}, mism, 0);
    if (v.dev_n > 0) begin
      repeat (2*US) tick;
      for (int i = v.dev_n - 1; i >= 0; i--) send_bit(v.dev_val[i]);
      if (v.dev_stop) begin
        dev_low = 1'b1;
        repeat (2*US) tick;
        dev_low = 1'b0;
      end
    end
    k = 0;
    while (done_cnt == base && k < 400) begin tick; k++; end
    repeat (4) tick;
    chk({nm, " done_pulses"}, done_cnt - base, 1);
    chk({nm, " busy_after"}, busy, 0);
    chk({nm, " timeout"}, d_to, v.exp_to);
    chk({nm, " rsp_count"}, d_cnt, v.exp_cnt);
    chk({nm, " rsp_data"}, d_data, v.exp_data);
    if (eff == 0) chk_rng({nm, " done_latency"}, d_cyc - sc, txc - 1, txc + 3);
    else if (v.dev_n == 0) chk_rng({nm, " timeout_latency"}, d_cyc - (sc + txc + 1), 29, 35);
  endtask

  vec_t vecs[20];

  initial begin
    int base, k;
    bit seen;
    vecs[0] = mk(24'(CMD_POLL), 8, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
    vecs[1] = mk(24'(CMD_POLL), 8, 32, 32'h8000_00FF, 32, 1, 0, 0, 32, 32'h8000_00FF);
    vecs[2] = mk(24'(CMD_POLL), 8, 32, 32'h0, 0, 0, 0, 1, 0, 32'h0);
    vecs[3] = mk(24'(CMD_POLL), 8, 32, 32'h2AA, 10, 0, 0, 1, 10, 32'h0000_02AA);
    vecs[4] = mk(24'(CMD_RESET), 8, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0);
    vecs[5] = mk(24'h000001, 0, 4, 32'hA, 4, 1, 0, 0, 4, 32'hA);
    vecs[6] = mk(24'(CMD_INFO), 8, 40, 32'h1234_5678, 32, 1, 0, 0, 32, 32'h1234_5678);
    vecs[7] = mk(24'hABCDEF, 24, 8, 32'h5A, 8, 1, 0, 0, 8, 32'h5A);
    for (int i = 8; i < 20; i++) begin
      vec_t v;
      v.cmd     = 24'($urandom);
      v.cmd_len = int'($urandom_range(0, CMAX));
      v.rsp_len = int'($urandom_range(0, RMAX));
      v.dev_n   = (v.rsp_len == 0) ? 0 : int'($urandom_range(0, RMAX));
      v.dev_val = (v.dev_n == 0) ? 32'h0 :
                  32'($urandom & ((64'h1 << v.dev_n) - 64'h1));
      v.dev_stop = (v.dev_n >= v.rsp_len);
      v.restart  = 1'b0;
      model(v);
      vecs[i] = v;
    end

    repeat (3) tick;
    Reset = 1'b0;
    tick;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset timeout", timeout, 0);
    chk("reset rsp_data", rsp_data, 0);
    chk("reset rsp_count", rsp_count, 0);
    chk("reset line", n64_line, 1);

    for (int i = 0; i < 20; i++) run_vec(i, vecs[i]);

    // start coincident with done must be dropped
    base = done_cnt;
    cmd = 24'h1; cmd_len = 5'd1; rsp_len = 6'd0;
    start = 1'b1; tick; start = 1'b0;
    seen = 1'b0; k = 0;
    while (!seen && k < 100) begin tick; k++; seen = done; end
    chk("start_at_done reached_done", seen, 1);
    start = 1'b1; tick; start = 1'b0;
    chk("start_at_done busy", busy, 0);
    chk("start_at_done line", n64_line, 1);
    repeat (40) tick;
    chk("start_at_done pulses", done_cnt - base, 1);

    // reset during TX_LOW of a 0 bit
    base = done_cnt;
    cmd = 24'h0; cmd_len = 5'd8; rsp_len = 6'd0;
    start = 1'b1; tick; start = 1'b0;
    repeat (4) tick;
    chk("midtx line_low", n64_line, 0);
    Reset = 1'b1; tick; Reset = 1'b0;
    chk("midtx reset line", n64_line, 1);
    chk("midtx reset busy", busy, 0);
    repeat (160) tick;
    chk("midtx no_done", done_cnt - base, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
